// File: rtl/mul5_pkg.sv
// Shared types and sizes for the 5x5 sequential multiplier.
// Build with MUL5_SIGNED_EN defined for two's-complement Booth operation.
package mul5_pkg;
   localparam int W     = 5;
   localparam int CNT_W = 3;
   localparam int ACC_W = 2 * W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic [ACC_W-1:0] acc_t;
endpackage

// File: rtl/mul5_seq_ctrl_if.sv
// Operand/result handshake bundle for mul5_seq_ctrl, plus debug visibility of the FSM.
interface mul5_seq_ctrl_if;
   import mul5_pkg::*;

   // A transfer happens on a rising clk edge where valid and ready are both high;
   // valid must not depend on ready, and the sender holds its payload until the transfer.
   logic           start_valid;
   logic           start_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           abort;
   logic           res_valid;
   logic           res_ready;
   logic [2*W-1:0] product;
   logic           busy;
   state_t         dbg_state;
   acc_t           dbg_acc;

   modport master (
      output start_valid, a, b, abort, res_ready,
      input  start_ready, res_valid, product, busy, dbg_state, dbg_acc
   );

   modport slave (
      input  start_valid, a, b, abort, res_ready,
      output start_ready, res_valid, product, busy, dbg_state, dbg_acc
   );
endinterface

// File: rtl/addsub5.sv
// 5-bit ripple adder/subtractor; cin=1 inverts b, giving a - b with the carry out in sum_o[5].
module addsub5
   import mul5_pkg::*;
(
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W:0]   sum_o
);
   logic [W-1:0] bx;
   logic         carry;

   assign bx = b_i ^ {W{cin_i}};

   always_comb begin
      sum_o = '0;
      carry = cin_i;
      for (int i = 0; i < W; i++) begin
         sum_o[i] = a_i[i] ^ bx[i] ^ carry;
         carry    = (a_i[i] & bx[i]) | (a_i[i] & carry) | (bx[i] & carry);
      end
      sum_o[W] = carry;
   end
endmodule

// File: rtl/mul5_seq_ctrl.sv
// Multi-cycle 5x5 shift-and-add multiplier reusing one addsub5 over W iterations.
// Define MUL5_SIGNED_EN to switch to radix-2 Booth with a signed 10-bit product.
module mul5_seq_ctrl
   import mul5_pkg::*;
(
   input logic            clk,
   input logic            rst_n,
   mul5_seq_ctrl_if.slave bus
);
   state_t           state_q, state_d;
   acc_t             p_q, p_d;
   logic [W-1:0]     mcand_q, mcand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     add_a, add_b;
   logic             add_cin;
   logic [W:0]       add_sum;
`ifdef MUL5_SIGNED_EN
   logic             pm1_q, pm1_d;
   logic             sign_ext;
`endif

   addsub5 u_addsub (
      .a_i   (add_a),
      .b_i   (add_b),
      .cin_i (add_cin),
      .sum_o (add_sum)
   );

   always_comb begin
      add_a   = p_q[2*W-1:W];
      add_b   = '0;
      add_cin = 1'b0;
`ifdef MUL5_SIGNED_EN
      case ({p_q[0], pm1_q})
         2'b01:   add_b = mcand_q;
         2'b10: begin
            add_b   = mcand_q;
            add_cin = 1'b1;
         end
         default: ;
      endcase
`else
      if (p_q[0]) add_b = mcand_q;
`endif
   end

`ifdef MUL5_SIGNED_EN
   // True sign of the 6-bit signed sum; the raw carry is not a sign bit.
   assign sign_ext = add_a[W-1] ^ add_b[W-1] ^ add_cin ^ add_sum[W];
`endif

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
`ifdef MUL5_SIGNED_EN
      pm1_d   = pm1_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start_valid) begin
               mcand_d = bus.a;
               p_d     = {1'b0, {W{1'b0}}, bus.b};
               cnt_d   = '0;
`ifdef MUL5_SIGNED_EN
               pm1_d   = 1'b0;
`endif
               state_d = CALC;
            end
         end
         CALC: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else begin
`ifdef MUL5_SIGNED_EN
               p_d   = {sign_ext, sign_ext, add_sum[W-1:0], p_q[W-1:1]};
               pm1_d = p_q[0];
`else
               p_d   = {1'b0, add_sum, p_q[W-1:1]};
`endif
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(W - 1)) state_d = DONE;
            end
         end
         DONE: begin
            if (bus.abort || bus.res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         p_q     <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
`ifdef MUL5_SIGNED_EN
         pm1_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
`ifdef MUL5_SIGNED_EN
         pm1_q   <= pm1_d;
`endif
      end
   end

   assign bus.start_ready = (state_q == IDLE);
   assign bus.res_valid   = (state_q == DONE);
   assign bus.busy        = (state_q != IDLE);
   assign bus.product     = (state_q == DONE) ? p_q[2*W-1:0] : '0;
   assign bus.dbg_state   = state_q;
   assign bus.dbg_acc     = p_q;
endmodule

// File: tb/tb_mul5_seq_ctrl.sv
// Directed bench for mul5_seq_ctrl; signed vectors run when MUL5_SIGNED_EN is defined.
module tb_mul5_seq_ctrl;
   import mul5_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [2*W-1:0] exp_q[$];

   always #5 clk = ~clk;

   mul5_seq_ctrl_if bus ();

   mul5_seq_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents operands for one edge, then scrambles a/b to show they are not resampled.
   task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
      bus.start_valid = 1'b1;
      bus.a = av;
      bus.b = bv;
      tick();
      bus.start_valid = 1'b0;
      bus.a = W'($urandom_range(0, 31));
      bus.b = W'($urandom_range(0, 31));
   endtask

   task automatic wait_result(output int edges, output bit timeout);
      edges   = 0;
      timeout = 1'b0;
      while (bus.res_valid !== 1'b1) begin
         if (edges >= 20) begin
            timeout = 1'b1;
            break;
         end
         tick();
         edges++;
      end
   endtask

   task automatic test_reset();
      #2;
      n_tests++;
      if (bus.start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ready: got %b expected 1", bus.start_ready); end
      n_tests++;
      if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
      n_tests++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_tests++;
      if (bus.product !== 10'd0) begin n_fail++; $display("FAIL reset_product: got %0d expected 0", bus.product); end
      #10 rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_calc();
      int e; bit to; logic [2*W-1:0] exp;
      bus.res_ready = 1'b1;
      start_op(5'd7, 5'd9);
      tick();
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (bus.dbg_state !== IDLE || bus.busy !== 1'b0 || bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0)
         begin n_fail++; $display("FAIL midreset_ctrl: state=%0d busy=%b sr=%b rv=%b expected 0 0 1 0", bus.dbg_state, bus.busy, bus.start_ready, bus.res_valid); end
      n_tests++;
      if (bus.dbg_acc !== 11'd0 || bus.product !== 10'd0)
         begin n_fail++; $display("FAIL midreset_acc: acc=%0d product=%0d expected 0 0", bus.dbg_acc, bus.product); end
      #3 rst_n = 1'b1;
      exp_q.push_back(10'd12);
      start_op(5'd3, 5'd4);
      wait_result(e, to);
      exp = exp_q.pop_front();
      n_tests++;
      if (to || bus.product !== exp) begin n_fail++; $display("FAIL after_reset_product: got %0d timeout=%b expected %0d", bus.product, to, exp); end
      tick();
   endtask

   task automatic test_max();
      int e; bit to;
      bus.res_ready = 1'b1;
      start_op(5'd31, 5'd31);
      wait_result(e, to);
      n_tests++;
      if (to || e != 5) begin n_fail++; $display("FAIL max_latency: got %0d edges timeout=%b expected 5", e, to); end
      n_tests++;
      if (bus.product !== 10'd961) begin n_fail++; $display("FAIL max_product: got %0d expected 961", bus.product); end
      tick();
      n_tests++;
      if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.start_ready !== 1'b1)
         begin n_fail++; $display("FAIL max_release: busy=%b rv=%b sr=%b expected 0 0 1", bus.busy, bus.res_valid, bus.start_ready); end
   endtask

   task automatic test_zero();
      int e; bit to;
      bus.res_ready = 1'b1;
      start_op(5'd0, 5'd17);
      wait_result(e, to);
      n_tests++;
      if (to || bus.product !== 10'd0) begin n_fail++; $display("FAIL zero_a_product: got %0d timeout=%b expected 0", bus.product, to); end
      tick();
      start_op(5'd13, 5'd0);
      wait_result(e, to);
      n_tests++;
      if (to || bus.product !== 10'd0) begin n_fail++; $display("FAIL zero_b_product: got %0d timeout=%b expected 0", bus.product, to); end
      tick();
   endtask

   task automatic test_stall();
      int e; bit to; bit bad;
      bus.res_ready = 1'b0;
      start_op(5'd6, 5'd5);
      wait_result(e, to);
      n_tests++;
      if (to || e != 5) begin n_fail++; $display("FAIL stall_latency: got %0d edges timeout=%b expected 5", e, to); end
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.start_valid = 1'b1;
         bus.a = 5'd1;
         bus.b = 5'd1;
         tick();
         if (bus.product !== 10'd30 || bus.res_valid !== 1'b1 || bus.start_ready !== 1'b0) bad = 1'b1;
      end
      bus.start_valid = 1'b0;
      n_tests++;
      if (bad) begin n_fail++; $display("FAIL stall_hold: product=%0d rv=%b sr=%b expected 30 1 0", bus.product, bus.res_valid, bus.start_ready); end
      bus.res_ready = 1'b1;
      tick();
      n_tests++;
      if (bus.dbg_state !== IDLE || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: state=%0d rv=%b expected 0 0", bus.dbg_state, bus.res_valid); end
   endtask

   task automatic test_abort();
      int e; bit to; bit seen;
      bus.res_ready = 1'b1;
      start_op(5'd20, 5'd20);
      tick();
      tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      n_tests++;
      if (bus.dbg_state !== IDLE || bus.busy !== 1'b0 || bus.start_ready !== 1'b1)
         begin n_fail++; $display("FAIL abort_calc: state=%0d busy=%b sr=%b expected 0 0 1", bus.dbg_state, bus.busy, bus.start_ready); end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (bus.res_valid !== 1'b0) seen = 1'b1;
         tick();
      end
      n_tests++;
      if (seen) begin n_fail++; $display("FAIL abort_no_result: got res_valid=1 expected 0"); end
      start_op(5'd2, 5'd3);
      wait_result(e, to);
      n_tests++;
      if (to || bus.product !== 10'd6) begin n_fail++; $display("FAIL abort_next_product: got %0d timeout=%b expected 6", bus.product, to); end
      tick();
   endtask

   task automatic test_abort_edges();
      int e; bit to;
      bus.res_ready = 1'b0;
      start_op(5'd9, 5'd9);
      wait_result(e, to);
      bus.abort = 1'b1;
      bus.res_ready = 1'b1;
      tick();
      n_tests++;
      if (bus.dbg_state !== IDLE || bus.res_valid !== 1'b0 || bus.product !== 10'd0)
         begin n_fail++; $display("FAIL abort_done: state=%0d rv=%b product=%0d expected 0 0 0", bus.dbg_state, bus.res_valid, bus.product); end
      bus.start_valid = 1'b1;
      bus.a = 5'd5;
      bus.b = 5'd6;
      tick();
      bus.start_valid = 1'b0;
      bus.abort = 1'b0;
      n_tests++;
      if (bus.dbg_state !== CALC || bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_idle_accept: state=%0d busy=%b expected 1 1", bus.dbg_state, bus.busy); end
      wait_result(e, to);
      n_tests++;
      if (to || e != 5 || bus.product !== 10'd30) begin n_fail++; $display("FAIL abort_idle_product: got %0d after %0d edges expected 30 after 5", bus.product, e); end
      tick();
   endtask

   task automatic test_back_to_back();
      int e; bit to; logic [2*W-1:0] exp;
      bus.res_ready = 1'b1;
      exp_q.push_back(10'd30);
`ifdef MUL5_SIGNED_EN
      exp_q.push_back(10'd165);
`else
      exp_q.push_back(10'd357);
`endif
      start_op(5'd10, 5'd3);
      wait_result(e, to);
      exp = exp_q.pop_front();
      n_tests++;
      if (to || bus.product !== exp) begin n_fail++; $display("FAIL b2b_first: got %0d expected %0d", bus.product, exp); end
      tick();
      start_op(5'd21, 5'd17);
      wait_result(e, to);
      exp = exp_q.pop_front();
      n_tests++;
      if (to || bus.product !== exp) begin n_fail++; $display("FAIL b2b_second: got %0d expected %0d", bus.product, exp); end
      tick();
   endtask

`ifdef MUL5_SIGNED_EN
   task automatic test_signed();
      int e; bit to;
      bus.res_ready = 1'b1;
      start_op(5'b10000, 5'b10000);
      wait_result(e, to);
      n_tests++;
      if (to || bus.product !== 10'd256) begin n_fail++; $display("FAIL signed_m16_m16: got %h expected 100", bus.product); end
      tick();
      start_op(5'b10000, 5'b01111);
      wait_result(e, to);
      n_tests++;
      if (to || bus.product !== 10'h310) begin n_fail++; $display("FAIL signed_m16_15: got %h expected 310", bus.product); end
      tick();
      start_op(5'b01111, 5'b11111);
      wait_result(e, to);
      n_tests++;
      if (to || bus.product !== 10'h3F1) begin n_fail++; $display("FAIL signed_15_m1: got %h expected 3f1", bus.product); end
      tick();
   endtask
`endif

   initial begin
      bus.start_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.abort = 1'b0;
      bus.res_ready = 1'b0;
      test_reset();
      test_reset_mid_calc();
`ifdef MUL5_SIGNED_EN
      test_signed();
`else
      test_max();
`endif
      test_zero();
      test_stall();
      test_abort();
      test_abort_edges();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mul5_seq_ctrl.md
Name: mul5_seq_ctrl

Overview:
- Multi-cycle unsigned 5x5 -> 10-bit shift-and-add multiplier controller.
- Sequences one shared 5-bit adder/subtractor: one add (or pass) per cycle over W iterations.
- Sits beside the ALU as a low-area multi-cycle unit.
- Uses valid/ready handshakes on both operand and result sides.

Parameters:
- W, 5, operand width; only W=5 is supported, since the adder datapath is 5 bits.
- CNT_W, 3, iteration counter width; must satisfy 2^CNT_W > W.

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  operands a/b valid
- start_ready  out  1  block can accept operands
- a  in  W  multiplicand
- b  in  W  multiplier
- abort  in  1  synchronous cancel of the current operation
- res_valid  out  1  product valid
- res_ready  in  1  consumer accepts product
- product  out  2W  result
- busy  out  1  high in CALC or DONE

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset (asserted at any time, including mid-operation) forces:
  - state=IDLE, P (2W+1-bit accumulator)=0, MCAND=0, count=0
  - start_ready=1, res_valid=0, busy=0, product=0
- States: IDLE, CALC, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&start_ready: MCAND<=a, P<={0,{W{0}},b}, count<=0, go to CALC.
- CALC, per cycle:
  - Adder operands: A=P[2W-1:W], B=MCAND if P[0]=1, else 0; cin=0 (add mode).
  - Adder output: 6-bit sum, bit 5 = carry out.
  - Update: P<={sum[5:0],P[W-1:0]}>>1 (logical shift right of the concatenation).
  - count<=count+1.
  - When count==W-1, go to DONE on the same edge.
- DONE:
  - res_valid=1; product=P[2W-1:0], held stable until handshake.
  - On res_valid&res_ready: go to IDLE.
- Latency:
  - res_valid rises exactly W clock edges after the accepting edge (W=5 -> 5 cycles).
  - The first new accept is possible the cycle after result handshake.
  - Throughput is one result per W+2 cycles minimum.
- start_ready=0 in CALC and DONE; start_valid there is ignored and a/b are not sampled.
- a/b are sampled only at the accept edge; later changes have no effect.
- Arithmetic:
  - Unsigned; the 10-bit product never overflows (max 31*31=961).
  - The adder's carry out is the 6th bit shifted into P.
- abort:
  - In CALC or DONE, abort=1 -> IDLE next edge, res_valid=0 and the result is discarded.
  - abort in IDLE has no effect.
  - abort has priority over the res handshake and over count terminal.
- Stall: res_ready low in DONE holds product/res_valid indefinitely.
- busy = (state != IDLE).
- Unused state encoding -> IDLE.

Optional Feature:
- Macro: MUL5_SIGNED_EN.
- Defined: two's-complement radix-2 Booth.
  - Extra bit P[-1], cleared on accept.
  - Per cycle on {P[0],P[-1]}: 01 -> add MCAND (cin=0); 10 -> subtract MCAND (cin=1, B inverted inside the adder); 00/11 -> pass.
  - Shift is arithmetic: the new MSB is the true sign of the untruncated 6-bit signed result, a[4]^b'[4]^c4, not the raw sum[5].
  - product is a signed 10-bit value.
- Undefined: unsigned behaviour exactly as above; cin is tied to 0.

Decomposition:
- Shared package mul5_pkg:
  - state_t enum {IDLE,CALC,DONE}
  - W localparam
  - typedef for the accumulator width
- One sub-module, addsub5:
  - a, b, cin -> 6-bit sum, 5-bit ripple.
  - Instantiated once and reused every CALC cycle; this is the shared resource.

Test Plan:
- Reset mid-CALC (a=7, b=9 accepted, rst_n low in cycle 2) -> all outputs at reset values immediately; next op a=3, b=4 -> product=12.
- a=31, b=31 accepted, res_ready=1 -> res_valid high exactly 5 edges later, product=961, busy falls next cycle.
- a=0, b=17 and a=13, b=0 -> product=0 both.
- a=6, b=5, res_ready held low 10 cycles -> product=30 stable, res_valid=1, start_ready=0 throughout, new start_valid ignored.
- abort asserted in 3rd CALC cycle of a=20, b=20 -> IDLE next edge, res_valid never rises; next op a=2, b=3 -> 6.
- With MUL5_SIGNED_EN:
  - a=-16, b=-16 -> 256
  - a=-16, b=15 -> -240 (10'h310)
  - a=15, b=-1 -> -15
